// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable countdown timer with 2-stage delayed enable
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   load     - load request, count takes load_val at the next edge
//   load_val - start value (N bits), sampled only when load=1
//   en       - decrement request, applied two edges after it is sampled
//   cnt      - registered current count
//   busy     - high while counting (RUN)
//   done     - one-cycle pulse on each entry to DONE
//   expired  - high while in DONE

module down_counter_timer #(
    parameter int unsigned N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    output logic [N-1:0] cnt,
    output logic         busy,
    output logic         done,
    output logic         expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] cnt_next;
    logic         done_next;
    logic         en_1;
    logic         en_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            en_1  <= 1'b0;
            en_2  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
            // A load discards enables in flight and the one sampled alongside it.
            if (load) begin
                en_1 <= 1'b0;
                en_2 <= 1'b0;
            end else begin
                en_1 <= en;
                en_2 <= en_1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        if (load) begin
            // Load wins over any decrement, in every state.
            cnt_next = load_val;
            if (load_val == '0) begin
                state_next = DONE;
                done_next  = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (en_2) begin
                        if (cnt > N'(1)) begin
                            cnt_next = cnt - N'(1);
                        end else begin
                            // RUN is only entered with a nonzero count, so this is 1 -> 0.
                            cnt_next   = '0;
                            state_next = DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
                // IDLE and DONE hold the count; en_2 is ignored so DONE cannot wrap.
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign expired = (state == DONE);

endmodule
